// File: rtl/arbitro_memoria_dados.sv
// Two-port arbiter in front of the single-port data memory (MenoriaDados).
// Port 0 is the processor data path, port 1 the loader/debug port.
module arbitro_memoria_dados #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int READ_LAT  = 1,
    parameter int PRIO_FIXA = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              We0,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack0,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData0,
    output logic [DATA_W-1:0] RData1,
    output logic [ADDR_W-1:0] Endereco,
    output logic [DATA_W-1:0] DadoEscr,
    output logic              MenWrite,
    output logic              MenRead,
    input  logic [DATA_W-1:0] DadoLido,
    output logic              Ocupado
);

    typedef enum logic [1:0] {
        LIVRE,
        ACESSO,
        CONCLUI
    } estado_t;

    localparam logic [2:0] CONT_FIM = 3'(READ_LAT - 1);

    estado_t           estado, estado_prox;
    logic              ultimo, ultimo_prox;
    logic              vencedor, vencedor_prox;
    logic              escrita, escrita_prox;
    logic [2:0]        cont, cont_prox;
    logic [ADDR_W-1:0] end_q, end_prox;
    logic [DATA_W-1:0] dado_q, dado_prox;
    logic              mw_q, mw_prox;
    logic              mr_q, mr_prox;
    logic              ack0_q, ack0_prox;
    logic              ack1_q, ack1_prox;
    logic [DATA_W-1:0] rd0_q, rd0_prox;
    logic [DATA_W-1:0] rd1_q, rd1_prox;
    logic              ganha0;

    // Port 0 wins a tie when priority is fixed or port 1 was served last.
    assign ganha0 = Req0 &&
                    (!Req1 || (PRIO_FIXA != 0) || ultimo);

    always_comb begin
        estado_prox   = estado;
        ultimo_prox   = ultimo;
        vencedor_prox = vencedor;
        escrita_prox  = escrita;
        cont_prox     = cont;
        end_prox      = end_q;
        dado_prox     = dado_q;
        mw_prox       = mw_q;
        mr_prox       = mr_q;
        ack0_prox     = 1'b0;
        ack1_prox     = 1'b0;
        rd0_prox      = rd0_q;
        rd1_prox      = rd1_q;

        unique case (estado)
            LIVRE: begin
                if (Req0 || Req1) begin
                    vencedor_prox = ~ganha0;
                    ultimo_prox   = ~ganha0;
                    escrita_prox  = ganha0 ? We0 : We1;
                    end_prox      = ganha0 ? Addr0 : Addr1;
                    dado_prox     = ganha0 ? WData0 : WData1;
                    mw_prox       = ganha0 ? We0 : We1;
                    mr_prox       = ganha0 ? ~We0 : ~We1;
                    cont_prox     = 3'd0;
                    estado_prox   = ACESSO;
                end
            end
            ACESSO: begin
                if (escrita) begin
                    mw_prox     = 1'b0;
                    ack0_prox   = ~vencedor;
                    ack1_prox   = vencedor;
                    estado_prox = CONCLUI;
                end else if (cont == CONT_FIM) begin
                    mr_prox     = 1'b0;
                    ack0_prox   = ~vencedor;
                    ack1_prox   = vencedor;
                    if (vencedor)
                        rd1_prox = DadoLido;
                    else
                        rd0_prox = DadoLido;
                    estado_prox = CONCLUI;
                end else begin
                    cont_prox = cont + 3'd1;
                end
            end
            CONCLUI: begin
                estado_prox = LIVRE;
            end
            default: begin
                estado_prox = LIVRE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado   <= LIVRE;
            ultimo   <= 1'b1;
            vencedor <= 1'b0;
            escrita  <= 1'b0;
            cont     <= 3'd0;
            end_q    <= '0;
            dado_q   <= '0;
            mw_q     <= 1'b0;
            mr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rd0_q    <= '0;
            rd1_q    <= '0;
        end else begin
            estado   <= estado_prox;
            ultimo   <= ultimo_prox;
            vencedor <= vencedor_prox;
            escrita  <= escrita_prox;
            cont     <= cont_prox;
            end_q    <= end_prox;
            dado_q   <= dado_prox;
            mw_q     <= mw_prox;
            mr_q     <= mr_prox;
            ack0_q   <= ack0_prox;
            ack1_q   <= ack1_prox;
            rd0_q    <= rd0_prox;
            rd1_q    <= rd1_prox;
        end
    end

    // Strobes are gated so nothing reaches memory while Reset is high.
    assign MenWrite = mw_q & ~Reset;
    assign MenRead  = mr_q & ~Reset;
    assign Endereco = end_q;
    assign DadoEscr = dado_q;
    assign Ack0     = ack0_q;
    assign Ack1     = ack1_q;
    assign RData0   = rd0_q;
    assign RData1   = rd1_q;
    assign Ocupado  = (estado != LIVRE);

endmodule
